// File: rtl/seq_divider_lattice_if.sv
// seq_divider_lattice_if: operand/result valid-ready bundle for the sequential divider.
interface seq_divider_lattice_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             div_by_zero;
    modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, q, r, div_by_zero);
    modport slave  (input in_valid, a, b, out_ready, output in_ready, out_valid, q, r, div_by_zero);
endinterface

// File: rtl/seq_divider_lattice.sv
// seq_divider_lattice: restoring shift-subtract unsigned divider, one quotient bit per cycle.
module seq_divider_lattice #(parameter int WIDTH = 16) (
    input logic clk,
    input logic rst,
    seq_divider_lattice_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, BUSY, ZERO, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] dvd, dvs, rem, quo;
    logic [CW-1:0]    cnt;
    logic             in_ready_r, out_valid_r, dbz;
    logic [WIDTH-1:0] rem_sh;
    logic [WIDTH:0]   diff;
    logic             ge;
    // one extra bit on the subtraction turns its borrow into the compare result
    always_comb begin
        rem_sh = {rem[WIDTH-2:0], dvd[WIDTH-1]};
        diff   = {1'b0, rem_sh} - {1'b0, dvs};
        ge     = ~diff[WIDTH];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            dvd         <= '0;
            dvs         <= '0;
            rem         <= '0;
            quo         <= '0;
            cnt         <= '0;
            dbz         <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    dvd        <= bus.a;
                    dvs        <= bus.b;
                    rem        <= '0;
                    quo        <= '0;
                    cnt        <= CW'(WIDTH - 1);
                    dbz        <= 1'b0;
                    in_ready_r <= 1'b0;
                    state      <= (bus.b == '0) ? ZERO : BUSY;
                end
                BUSY: begin
                    dvd <= dvd << 1;
                    rem <= ge ? diff[WIDTH-1:0] : rem_sh;
                    quo <= {quo[WIDTH-2:0], ge};
                    if (cnt == '0) begin
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ZERO: begin
                    quo         <= '1;
                    rem         <= dvd;
                    dbz         <= 1'b1;
                    state       <= DONE;
                    out_valid_r <= 1'b1;
                end
                DONE: if (bus.out_ready) begin
                    state       <= IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.in_ready    = in_ready_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.q           = quo;
    assign bus.r           = rem;
    assign bus.div_by_zero = dbz;
endmodule

// File: tb/tb_seq_divider_lattice.sv
// tb_seq_divider_lattice: vector table plus scoreboarded random traffic for the sequential divider.
module tb_seq_divider_lattice;
    localparam int W = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    seq_divider_lattice_if #(.WIDTH(W)) bus();
    seq_divider_lattice #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {logic [W-1:0] q; logic [W-1:0] r; logic dbz; int acc;} exp_t;
    typedef struct {logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] q; logic [W-1:0] r; logic dbz;} vec_t;
    exp_t sb[$];
    int checks = 0, errors = 0, cyc = 0, rdy_mode = 0;
    logic prev_hold = 1'b0, prev_hand = 1'b0, hold_dbz, last_dbz;
    logic [W-1:0] hold_q, hold_r, last_q, last_r;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor: scoreboard push on accept, compare/pop on result, hold-stability while stalled
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            sb.delete();
            prev_hold = 1'b0;
            prev_hand = 1'b0;
        end else begin
            if (prev_hand) chk("in_ready_after_handoff", 32'(bus.in_ready), 1);
            prev_hand = 1'b0;
            if (bus.in_valid && bus.in_ready) begin
                exp_t e;
                e.q   = (bus.b == '0) ? '1 : bus.a / bus.b;
                e.r   = (bus.b == '0) ? bus.a : bus.a % bus.b;
                e.dbz = (bus.b == '0);
                e.acc = cyc;
                sb.push_back(e);
            end
            if (prev_hold) begin
                chk("out_valid_held", 32'(bus.out_valid), 1);
                chk("q_stable", 32'(bus.q), 32'(hold_q));
                chk("r_stable", 32'(bus.r), 32'(hold_r));
                chk("dbz_stable", 32'(bus.div_by_zero), 32'(hold_dbz));
            end
            if (bus.out_valid) begin
                chk("in_ready_low_in_done", 32'(bus.in_ready), 0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got q=%0d r=%0d with no pending operation", bus.q, bus.r);
                end else begin
                    if (!prev_hold) chk("latency", 32'(cyc - sb[0].acc), sb[0].dbz ? 32'd2 : 32'(W + 1));
                    chk("sb_q", 32'(bus.q), 32'(sb[0].q));
                    chk("sb_r", 32'(bus.r), 32'(sb[0].r));
                    chk("sb_dbz", 32'(bus.div_by_zero), 32'(sb[0].dbz));
                    if (bus.out_ready) begin
                        last_q    = bus.q;
                        last_r    = bus.r;
                        last_dbz  = bus.div_by_zero;
                        prev_hand = 1'b1;
                        void'(sb.pop_front());
                    end
                end
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            hold_q    = bus.q;
            hold_r    = bus.r;
            hold_dbz  = bus.div_by_zero;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        bus.out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        while (1) begin
            @(negedge clk);
            if (bus.in_ready) break;
            if (++n > 1000) begin
                $display("FAIL accept_timeout: in_ready never rose for a=%0d b=%0d", a, b);
                $fatal(1);
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (1) begin
            @(negedge clk);
            if (sb.size() == 0 && bus.in_ready && !bus.out_valid) break;
            if (++n > 1000) begin
                checks++;
                errors++;
                $display("FAIL done_timeout: got pending=%0d required 0", sb.size());
                break;
            end
        end
    endtask

    vec_t vecs[10];

    initial begin
        int n;
        vecs[0] = '{16'd100,   16'd7,     16'd14,    16'd2,    1'b0};
        vecs[1] = '{16'hFFFF,  16'h0001,  16'hFFFF,  16'd0,    1'b0};
        vecs[2] = '{16'h0005,  16'h0009,  16'd0,     16'd5,    1'b0};
        vecs[3] = '{16'd1234,  16'd0,     16'hFFFF,  16'd1234, 1'b1};
        vecs[4] = '{16'd10,    16'd3,     16'd3,     16'd1,    1'b0};
        vecs[5] = '{16'd0,     16'd5,     16'd0,     16'd0,    1'b0};
        vecs[6] = '{16'd7,     16'd7,     16'd1,     16'd0,    1'b0};
        vecs[7] = '{16'hFFFF,  16'hFFFF,  16'd1,     16'd0,    1'b0};
        vecs[8] = '{16'hFFFE,  16'h8001,  16'd1,     16'h7FFD, 1'b0};
        vecs[9] = '{16'd0,     16'd0,     16'hFFFF,  16'd0,    1'b1};
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_q", 32'(bus.q), 0);
        chk("rst_r", 32'(bus.r), 0);
        chk("rst_dbz", 32'(bus.div_by_zero), 0);
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b);
            wait_done();
            chk("vec_q", 32'(last_q), 32'(vecs[i].q));
            chk("vec_r", 32'(last_r), 32'(vecs[i].r));
            chk("vec_dbz", 32'(last_dbz), 32'(vecs[i].dbz));
        end
        // long backpressure with ignored operand pulses
        rdy_mode = 2;
        do_op(16'd60000, 16'd255);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid", 32'(bus.out_valid), 1);
        repeat (20) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.a = 16'd1;
            bus.b = 16'd1;
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        rdy_mode = 0;
        wait_done();
        chk("bp_q", 32'(last_q), 235);
        chk("bp_r", 32'(last_r), 75);
        // reset in the middle of an operation
        do_op(16'd500, 16'd3);
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", 32'(bus.out_valid), 0);
        chk("abort_q", 32'(bus.q), 0);
        chk("abort_r", 32'(bus.r), 0);
        chk("abort_in_ready", 32'(bus.in_ready), 1);
        repeat (20) begin
            @(negedge clk);
            chk("abort_no_result", 32'(bus.out_valid), 0);
        end
        do_op(16'd500, 16'd3);
        wait_done();
        chk("abort_next_q", 32'(last_q), 166);
        chk("abort_next_r", 32'(last_r), 2);
        // random traffic with random output backpressure
        rdy_mode = 1;
        for (int i = 0; i < 2000; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = ($urandom_range(0, 15) == 0) ? '0 : ($urandom_range(0, 3) == 0) ? W'($urandom_range(1, 20)) : W'($urandom);
            do_op(ra, rb);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        rdy_mode = 0;
        wait_done();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_divider_lattice.md
Name: seq_divider_lattice

Overview:
- Iterative unsigned divider producing quotient and remainder: the inverse operation of the team's DSP-mapped `p = a * b` multiplier flow.
- Intended as a sequential synthesis target for the lattice-ecp5 flow and as the reference model for multiplier round-trip checks (`(a*b)/b == a`).
- Restoring shift-subtract algorithm, one quotient bit per cycle.
- Valid/ready handshakes on both input and output sides.

Parameters:
- WIDTH, 16, bit width of dividend, divisor, quotient and remainder; legal range 2..32.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a/b operands are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  dividend, unsigned.
- b  input  WIDTH  divisor, unsigned.
- out_valid  output  1  q/r/div_by_zero are valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- q  output  WIDTH  quotient, a / b.
- r  output  WIDTH  remainder, a % b.
- div_by_zero  output  1  set when the accepted b was 0.

Behaviour:
- Reset: state=IDLE; in_ready=1 on the cycle after reset; out_valid=0, q=0, r=0, div_by_zero=0; iteration counter=0. Reset mid-BUSY or mid-DONE aborts the operation and discards the result, with no out_valid pulse.
- States:
  - IDLE: in_ready=1. On in_valid, latch a into the dividend shift register, latch b, clear the partial remainder, load counter=WIDTH-1. Go to ZERO if b==0, else BUSY.
  - BUSY: each cycle
    - rem' = {rem[WIDTH-2:0], dividend MSB};
    - shift dividend left;
    - if rem' >= b then rem = rem'-b and shift in quotient bit 1, else rem = rem' and shift in 0.
    - The subtraction uses WIDTH+1 bits so no overflow occurs.
    - When counter==0, go to DONE; else decrement counter.
  - ZERO: single cycle; q = all ones, r = a, div_by_zero=1; go to DONE.
  - DONE: out_valid=1; q/r/div_by_zero stable. On out_ready, go to IDLE and deassert out_valid.
- Latency, counted from the accepting edge (in_valid & in_ready) to the first cycle with out_valid=1:
  - b != 0: exactly WIDTH+1 cycles.
  - b == 0: exactly 2 cycles.
- Throughput: one operation per WIDTH+2 cycles minimum, since IDLE is re-entered for one cycle after result handoff.
- Handshake rules:
  - in_ready=0 in BUSY/ZERO/DONE; in_valid is ignored there, and a/b changes have no effect after acceptance.
  - out_valid, once asserted, holds until out_ready is sampled high. q/r/div_by_zero do not change while out_valid=1.
  - Backpressure of any length is legal.
  - out_ready high with out_valid low is ignored.
  - No accept occurs in the same cycle as result handoff: IDLE accepts the next operation no earlier than the cycle after handoff.
- Outputs after handoff: q/r hold their last values (don't-care) while out_valid=0. div_by_zero clears on the next accept.
- Arithmetic:
  - All values unsigned.
  - Invariant for b != 0: a == q*b + r and r < b.
  - a < b gives q=0, r=a.
  - b=1 gives q=a, r=0.
  - a=0 gives q=0, r=0.

Test Plan:
- Reset, then a=100, b=7, out_ready=1 -> out_valid rises exactly 17 cycles after accept; q=14, r=2, div_by_zero=0; in_ready returns 1 one cycle after handoff.
- a=16'hFFFF, b=16'h0001, then a=16'h0005, b=16'h0009 -> (q=16'hFFFF, r=0), then (q=0, r=5).
- a=1234, b=0 -> out_valid 2 cycles after accept; q=16'hFFFF, r=1234, div_by_zero=1. Next op a=10, b=3 -> q=3, r=1, div_by_zero=0.
- a=60000, b=255, out_ready held 0 for 20 cycles -> out_valid stays 1, q=235, r=75 stable throughout; in_valid pulses during this window are ignored; handoff occurs on the first out_ready=1.
- Assert rst at cycle 8 of BUSY (a=500, b=3) -> next cycle in IDLE with out_valid=0, q=0, r=0; no result ever emitted; subsequent a=500, b=3 -> q=166, r=2.
- 2000 random (a,b) pairs with random out_ready/in_valid gaps -> every result satisfies a==q*b+r, r<b (or the b==0 rule); latency always 17 cycles, or 2 cycles when b==0.
